// File: rtl/uncache_wbuf_ctrl_if.sv
// CPU-side uncached request port plus AXI3 master bus for uncache_wbuf_ctrl.
// master = the controller, slave = CPU/interconnect side.
interface uncache_wbuf_ctrl_if;
   logic        data_req;
   logic        data_op;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;

   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [3:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [1:0]  arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;

   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [3:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic [1:0]  awlock;
   logic [3:0]  awcache;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;

   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;

   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      input  data_req, data_op, data_size, data_addr, data_wstrb, data_wdata,
      output data_addr_ok, data_data_ok, data_rdata,
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
      output arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready,
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
      output awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready
   );

   modport slave (
      output data_req, data_op, data_size, data_addr, data_wstrb, data_wdata,
      input  data_addr_ok, data_data_ok, data_rdata,
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
      input  arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready,
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
      input  awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready
   );
endinterface

// File: rtl/uncache_wbuf_ctrl.sv
// Uncached access controller: single outstanding AXI read, posted writes
// through a circular buffer drained one AXI write at a time, in order.
module uncache_wbuf_ctrl #(
   parameter int       WBUF_DEPTH = 4,
   parameter logic [3:0] RD_ID    = 4'd11,
   parameter logic [3:0] WR_ID    = 4'd7
) (
   input  logic                       clk,
   input  logic                       reset,
   uncache_wbuf_ctrl_if.master        bus,
   output logic                       bus_err
);

   localparam int PW = $clog2(WBUF_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(WBUF_DEPTH);

   typedef enum logic [1:0] {R_IDLE, R_AR, R_R} r_state_e;
   typedef enum logic [1:0] {W_IDLE, W_AW, W_W, W_B} w_state_e;

   typedef struct packed {
      logic [31:0] addr;
      logic [1:0]  size;
      logic [3:0]  strb;
      logic [31:0] data;
   } ent_t;

   r_state_e      r_state_q, r_state_d;
   w_state_e      w_state_q, w_state_d;
   logic [31:0]   raddr_q, raddr_d;
   logic [1:0]    rsize_q, rsize_d;
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          wack_q, wack_d;
   logic          err_q, err_d;
   ent_t          buf_q [WBUF_DEPTH];
   ent_t          buf_d [WBUF_DEPTH];
   ent_t          head_e;

   logic rd_ok, wr_ok, acc, push, rd_acc, pop, r_hs, r_done;
   logic unused_ok;

   // Reads wait for every posted write to finish so they never overtake one.
   assign rd_ok  = (r_state_q == R_IDLE) && (cnt_q == '0) &&
                   (w_state_q == W_IDLE) && !wack_q;
   assign wr_ok  = (r_state_q == R_IDLE) && (cnt_q != FULL);
   assign acc    = bus.data_req && (bus.data_op ? wr_ok : rd_ok);
   assign push   = acc && bus.data_op;
   assign rd_acc = acc && !bus.data_op;
   assign pop    = (w_state_q == W_B) && bus.bvalid;
   assign r_hs   = (r_state_q == R_R) && bus.rvalid;
   assign r_done = r_hs && bus.rlast;
   assign head_e = buf_q[head_q];

   always_comb begin
      r_state_d = r_state_q;
      w_state_d = w_state_q;
      raddr_d   = raddr_q;
      rsize_d   = rsize_q;
      head_d    = head_q;
      tail_d    = tail_q;
      cnt_d     = cnt_q;
      buf_d     = buf_q;
      wack_d    = push;
      err_d     = err_q;

      unique case (r_state_q)
         R_IDLE: if (rd_acc) begin
            r_state_d = R_AR;
            raddr_d   = bus.data_addr;
            rsize_d   = bus.data_size;
         end
         R_AR:   if (bus.arready) r_state_d = R_R;
         R_R:    if (r_done) r_state_d = R_IDLE;
         default: r_state_d = R_IDLE;
      endcase

      unique case (w_state_q)
         W_IDLE: if (cnt_q != '0) w_state_d = W_AW;
         W_AW:   if (bus.awready) w_state_d = W_W;
         W_W:    if (bus.wready) w_state_d = W_B;
         W_B:    if (bus.bvalid) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase

      if (push) begin
         buf_d[tail_q] = '{addr: bus.data_addr, size: bus.data_size,
                           strb: bus.data_wstrb, data: bus.data_wdata};
         tail_d = tail_q + 1'b1;
      end
      if (pop) head_d = head_q + 1'b1;

      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase

      if ((r_hs && bus.rresp != 2'b00) || (pop && bus.bresp != 2'b00))
         err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state_q <= R_IDLE;
         w_state_q <= W_IDLE;
         raddr_q   <= '0;
         rsize_q   <= '0;
         head_q    <= '0;
         tail_q    <= '0;
         cnt_q     <= '0;
         wack_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         r_state_q <= r_state_d;
         w_state_q <= w_state_d;
         raddr_q   <= raddr_d;
         rsize_q   <= rsize_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         cnt_q     <= cnt_d;
         wack_q    <= wack_d;
         err_q     <= err_d;
      end
   end

   // Payload storage needs no reset; occupancy is tracked by cnt_q.
   always_ff @(posedge clk) begin
      buf_q <= buf_d;
   end

   assign bus.data_addr_ok = acc;
   assign bus.data_data_ok = wack_q | r_done;
   assign bus.data_rdata   = bus.rdata;
   assign bus_err          = err_q;

   assign bus.arid    = RD_ID;
   assign bus.araddr  = raddr_q;
   assign bus.arlen   = 4'd0;
   assign bus.arsize  = {1'b0, rsize_q};
   assign bus.arburst = 2'd0;
   assign bus.arlock  = 2'd0;
   assign bus.arcache = 4'd0;
   assign bus.arprot  = 3'd0;
   assign bus.arvalid = (r_state_q == R_AR);
   assign bus.rready  = (r_state_q == R_R);

   assign bus.awid    = WR_ID;
   assign bus.awaddr  = head_e.addr;
   assign bus.awlen   = 4'd0;
   assign bus.awsize  = {1'b0, head_e.size};
   assign bus.awburst = 2'd0;
   assign bus.awlock  = 2'd0;
   assign bus.awcache = 4'd0;
   assign bus.awprot  = 3'd0;
   assign bus.awvalid = (w_state_q == W_AW);

   assign bus.wid     = WR_ID;
   assign bus.wdata   = head_e.data;
   assign bus.wstrb   = head_e.strb;
   assign bus.wvalid  = (w_state_q == W_W);
   assign bus.wlast   = (w_state_q == W_W);
   assign bus.bready  = (w_state_q == W_B);

   assign unused_ok = ^{bus.rid, bus.bid};

endmodule

// File: tb/tb_uncache_wbuf_ctrl.sv
// Random CPU traffic and AXI slave behaviour checked against a
// transaction-level model of ordering, buffering and acknowledgements.
module tb_uncache_wbuf_ctrl;
   localparam int DEPTH = 4;
   localparam int NCYC  = 3000;

   logic clk = 1'b0;
   logic reset;
   logic bus_err;

   always #5 clk = ~clk;

   uncache_wbuf_ctrl_if bus ();

   uncache_wbuf_ctrl #(.WBUF_DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .bus_err (bus_err)
   );

   typedef struct {
      logic [31:0] a;
      logic [1:0]  s;
      logic [3:0]  st;
      logic [31:0] d;
   } wr_t;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   wr_t         q[$];
   bit          wack, rd_busy, ar_done, aw_done, w_done, err;
   logic [31:0] rd_addr;
   logic [1:0]  rd_size;
   bit          do_rst, post;
   int          resets, n_acc, n_drain, n_rd;

   task automatic drive_idle();
      bus.data_req   = 1'b0;
      bus.data_op    = 1'b0;
      bus.data_size  = 2'd0;
      bus.data_addr  = '0;
      bus.data_wstrb = '0;
      bus.data_wdata = '0;
      bus.arready    = 1'b0;
      bus.rid        = 4'd11;
      bus.rdata      = '0;
      bus.rresp      = 2'b00;
      bus.rlast      = 1'b1;
      bus.rvalid     = 1'b0;
      bus.awready    = 1'b0;
      bus.wready     = 1'b0;
      bus.bid        = 4'd7;
      bus.bresp      = 2'b00;
      bus.bvalid     = 1'b0;
   endtask

   task automatic model_clear();
      q.delete();
      wack = 0; rd_busy = 0; ar_done = 0;
      aw_done = 0; w_done = 0; err = 0;
   endtask

   initial begin
      bit fill, drain, ok_rd, ok_wr, pacc, rd_fin, b_fin;
      bit aw_hs, w_hs, ar_hs;
      wr_t e;
      drive_idle();
      model_clear();
      reset = 1'b1;
      do_rst = 0; post = 1; resets = 0;
      n_acc = 0; n_drain = 0; n_rd = 0;
      repeat (2) @(posedge clk);

      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(negedge clk);
         if (do_rst) begin
            reset = 1'b1;
            drive_idle();
            model_clear();
            do_rst = 0;
            post = 1;
            resets++;
            continue;
         end
         reset = 1'b0;
         fill  = (cyc < 60);
         drain = (cyc >= NCYC - 300);

         bus.data_req   = !drain && ($urandom_range(0, 99) < 60);
         bus.data_op    = fill ? 1'b1 : 1'($urandom_range(0, 1));
         bus.data_size  = 2'($urandom_range(0, 2));
         bus.data_addr  = $urandom;
         bus.data_wstrb = 4'($urandom);
         bus.data_wdata = $urandom;
         bus.arready    = drain || ($urandom_range(0, 1) == 1);
         bus.awready    = !fill && (drain || ($urandom_range(0, 2) != 0));
         bus.wready     = drain || ($urandom_range(0, 2) != 0);
         bus.rvalid     = ar_done && (drain || ($urandom_range(0, 2) == 0));
         bus.rdata      = $urandom;
         bus.rresp      = ($urandom_range(0, 29) == 0) ? 2'b10 : 2'b00;
         bus.rlast      = 1'b1;
         bus.bvalid     = w_done && (drain || ($urandom_range(0, 2) == 0));
         bus.bresp      = ($urandom_range(0, 29) == 0) ? 2'b10 : 2'b00;
         #1;

         if (post) begin
            chk("rst_arvalid", bus.arvalid, 0);
            chk("rst_awvalid", bus.awvalid, 0);
            chk("rst_wvalid", bus.wvalid, 0);
            chk("rst_bready", bus.bready, 0);
            chk("rst_rready", bus.rready, 0);
            chk("rst_data_ok", bus.data_data_ok, 0);
            chk("rst_bus_err", bus_err, 0);
            post = 0;
         end

         ok_rd  = !rd_busy && (q.size() == 0) && !wack;
         ok_wr  = !rd_busy && (q.size() < DEPTH);
         pacc   = bus.data_req && (bus.data_op ? ok_wr : ok_rd);
         rd_fin = bus.rvalid && ar_done;
         b_fin  = bus.bvalid && w_done;

         chk("addr_ok", bus.data_addr_ok, pacc);
         chk("data_ok", bus.data_data_ok, wack || rd_fin);
         if (rd_fin) chk("rdata", bus.data_rdata, bus.rdata);
         chk("rready", bus.rready, ar_done);
         chk("bready", bus.bready, w_done);
         chk("wvalid", bus.wvalid, aw_done && !w_done);
         chk("wlast", bus.wlast, aw_done && !w_done);
         chk("bus_err", bus_err, err);

         if (bus.arvalid) begin
            chk("ar_legal", {rd_busy, ar_done}, 2'b10);
            chk("araddr", bus.araddr, rd_addr);
            chk("arsize", bus.arsize, {1'b0, rd_size});
            chk("arid", bus.arid, 4'd11);
            chk("arlen", bus.arlen, 0);
         end
         if (bus.awvalid) begin
            chk("aw_legal", {q.size() > 0, aw_done}, 2'b10);
            if (q.size() > 0) begin
               chk("awaddr", bus.awaddr, q[0].a);
               chk("awsize", bus.awsize, {1'b0, q[0].s});
            end
            chk("awid", bus.awid, 4'd7);
            chk("awlen", bus.awlen, 0);
         end
         if (bus.wvalid && q.size() > 0) begin
            chk("wdata", bus.wdata, q[0].d);
            chk("wstrb", bus.wstrb, q[0].st);
            chk("wid", bus.wid, 4'd7);
         end

         ar_hs = bus.arvalid && bus.arready && rd_busy && !ar_done;
         aw_hs = bus.awvalid && bus.awready && q.size() > 0 && !aw_done;
         w_hs  = bus.wvalid && bus.wready && aw_done && !w_done;

         if ((rd_fin && bus.rresp != 0) || (b_fin && bus.bresp != 0))
            err = 1;
         if (b_fin) begin
            void'(q.pop_front());
            aw_done = 0;
            w_done  = 0;
            n_drain++;
         end
         if (aw_hs) aw_done = 1;
         if (w_hs) w_done = 1;
         if (ar_hs) ar_done = 1;
         if (rd_fin) begin
            rd_busy = 0;
            ar_done = 0;
            n_rd++;
         end
         if (pacc && bus.data_op) begin
            e.a  = bus.data_addr;
            e.s  = bus.data_size;
            e.st = bus.data_wstrb;
            e.d  = bus.data_wdata;
            q.push_back(e);
            n_acc++;
         end
         if (pacc && !bus.data_op) begin
            rd_busy = 1;
            ar_done = 0;
            rd_addr = bus.data_addr;
            rd_size = bus.data_size;
         end
         wack = pacc && bus.data_op;

         if (!drain && cyc > 300 && resets < 3 && bus.wvalid &&
             q.size() >= 2 && $urandom_range(0, 3) == 0)
            do_rst = 1;
      end

      @(negedge clk);
      chk("end_wbuf_empty", q.size(), 0);
      chk("end_rd_idle", rd_busy, 0);
      chk("end_awvalid", bus.awvalid, 0);
      chk("end_arvalid", bus.arvalid, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
